// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-requester RAM arbiter: FSM state
// encoding and the default RAM geometry.
package ram_arb_pkg;

    // Default RAM geometry: 4 locations of 1 bit
    localparam int AW_DEFAULT = 2;
    localparam int DW_DEFAULT = 1;

    // Access sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2
    } state_t;

endpackage

// File: rtl/ram_rr_arbiter_rr_pick2.sv
// Two-way arbitration decision. On a tie the requester that was not
// served last wins; a lone requester always wins.
module rr_pick2
    import ram_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner
);

    // Combinational winner selection (0 = requester 0, 1 = requester 1)
    always_comb begin
        // NOTE: default assignment first so every path drives winner and no latch is inferred.
        winner = 1'b0;
        if (req0 && req1) begin
            winner = ~last;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/ram_rr_arbiter.sv
// Arbitrates two requesters onto a single registered-read RAM (ram_4x1).
// Sequence per access: IDLE (latch winner) -> ACCESS (gnt, RAM cycle)
// -> RDWAIT for reads (capture ram_dout, pulse rvalid next cycle).
// Build option: define RAM_ARB_FIXED_PRIO_EN for fixed priority
// (requester 0 wins ties); the last-served pointer is then not built.
module ram_rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] din0,
    input  logic [DW-1:0] din1,
    output logic          gnt0,
    output logic          gnt1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    state_t state;
    logic   lat_id;     // requester owning the access in flight
    logic   any_req;
    logic   winner;
    logic   last_sel;   // last-served id seen by the picker

    assign any_req = req0 | req1;

`ifdef RAM_ARB_FIXED_PRIO_EN
    // Pretending requester 1 was always served last makes requester 0 win every tie
    assign last_sel = 1'b1;
`else
    logic last_q;

    // Last-served pointer: moves to the winner whenever a grant is launched
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so all of them sample pre-edge values.
        if (rst) begin
            last_q <= 1'b1;
        end else if (state == IDLE && any_req) begin
            last_q <= winner;
        end
    end

    assign last_sel = last_q;
`endif

    rr_pick2 u_pick (
        .req0   (req0),
        .req1   (req1),
        .last   (last_sel),
        .winner (winner)
    );

    // Access sequencer with registered grant, RAM and read-data outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lat_id   <= 1'b0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
        end else begin
            // Pulses default low; ram_addr/ram_din/rdata hold unless loaded below
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            ram_we  <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        lat_id   <= winner;
                        ram_we   <= winner ? we1   : we0;
                        ram_addr <= winner ? addr1 : addr0;
                        ram_din  <= winner ? din1  : din0;
                        gnt0     <= ~winner;
                        gnt1     <= winner;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    // ram_we still carries the latched direction during ACCESS
                    state <= ram_we ? IDLE : RDWAIT;
                end
                RDWAIT: begin
                    if (lat_id) begin
                        rdata1  <= ram_dout;
                        rvalid1 <= 1'b1;
                    end else begin
                        rdata0  <= ram_dout;
                        rvalid0 <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Directed self-checking bench for ram_rr_arbiter with a behavioural
// registered-read 4x1 RAM attached to the RAM port.
module tb_ram_rr_arbiter;
    import ram_arb_pkg::*;

    localparam int AW = AW_DEFAULT;
    localparam int DW = DW_DEFAULT;
`ifdef RAM_ARB_FIXED_PRIO_EN
    localparam bit RR_MODE = 1'b0;
`else
    localparam bit RR_MODE = 1'b1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] din0, din1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    logic [DW-1:0] mem [4];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ram_rr_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .req1     (req1),
        .we0      (we0),
        .we1      (we1),
        .addr0    (addr0),
        .addr1    (addr1),
        .din0     (din0),
        .din1     (din1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    // Behavioural RAM: synchronous write, registered read
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Grants and read-valids must never overlap
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            check("onehot_gnt", {31'd0, gnt0 & gnt1}, 32'd0);
            check("onehot_rvalid", {31'd0, rvalid0 & rvalid1}, 32'd0);
        end
    end

    task automatic set_req(input bit id, input logic r, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (id) begin
            req1 = r; we1 = w; addr1 = a; din1 = d;
        end else begin
            req0 = r; we0 = w; addr0 = a; din0 = d;
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_gnt"},    {gnt1, gnt0}, 0);
        check({tag, "_rvalid"}, {rvalid1, rvalid0}, 0);
        check({tag, "_rdata"},  {rdata1, rdata0}, 0);
        check({tag, "_ram_we"}, ram_we, 0);
        check({tag, "_ram_addr"}, ram_addr, 0);
        check({tag, "_ram_din"},  ram_din, 0);
    endtask

    // Starts and ends at a negedge while the FSM is idle
    task automatic do_write(input bit id, input logic [AW-1:0] a, input logic [DW-1:0] d);
        set_req(id, 1'b1, 1'b1, a, d);
        @(negedge clk);
        check("wr_gnt", {gnt1, gnt0}, id ? 2'b10 : 2'b01);
        check("wr_ram_we", ram_we, 1);
        check("wr_ram_addr", ram_addr, a);
        check("wr_ram_din", ram_din, d);
        set_req(id, 1'b0, 1'b0, a, d);
        @(negedge clk);
        check("wr_we_low", ram_we, 0);
        check("wr_addr_hold", ram_addr, a);
    endtask

    task automatic do_read(input bit id, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        set_req(id, 1'b1, 1'b0, a, '0);
        @(negedge clk);
        check("rd_gnt", {gnt1, gnt0}, id ? 2'b10 : 2'b01);
        check("rd_ram_we", ram_we, 0);
        check("rd_ram_addr", ram_addr, a);
        set_req(id, 1'b0, 1'b0, a, '0);
        @(negedge clk);
        check("rd_rvalid_early", {rvalid1, rvalid0}, 0);
        @(negedge clk);
        check("rd_rvalid", {rvalid1, rvalid0}, id ? 2'b10 : 2'b01);
        check("rd_rdata", id ? rdata1 : rdata0, exp);
    endtask

    logic [3:0] d0, d1;
    int         k0, k1;
    bit         exp_id;

    initial begin
        for (int i = 0; i < 4; i++) mem[i] = '0;
        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;

        // Single write then read from requester 0
        do_write(0, 2'd2, 1'b1);
        do_read(0, 2'd2, 1'b1);
        @(negedge clk);
        check("rdata0_hold", rdata0, 1);
        check("rvalid0_pulse", rvalid0, 0);

        // Tie after reset; requester 0 re-requests so the second arbitration is also a tie
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_req(0, 1'b1, 1'b0, 2'd2, '0);
        set_req(1, 1'b1, 1'b0, 2'd0, '0);
        @(negedge clk);
        check("tie1_gnt", {gnt1, gnt0}, 2'b01);
        addr0 = 2'd3;
        @(negedge clk);
        check("tie1_rvalid_early", {rvalid1, rvalid0}, 0);
        @(negedge clk);
        check("tie1_rvalid", {rvalid1, rvalid0}, 2'b01);
        check("tie1_rdata0", rdata0, 1);
        @(negedge clk);
        check("tie2_gnt", {gnt1, gnt0}, RR_MODE ? 2'b10 : 2'b01);
        if (RR_MODE) req1 = 1'b0; else req0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("tie2_rvalid", {rvalid1, rvalid0}, RR_MODE ? 2'b10 : 2'b01);
        check("tie2_rdata", RR_MODE ? rdata1 : rdata0, 0);
        @(negedge clk);
        check("tie3_gnt", {gnt1, gnt0}, RR_MODE ? 2'b01 : 2'b10);
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(negedge clk);
        check("tie3_rvalid", {rvalid1, rvalid0}, RR_MODE ? 2'b01 : 2'b10);

        // Persistent write contention over addresses 0..3
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        d0 = 4'b1100;
        d1 = 4'b0011;
        k0 = 0;
        k1 = 0;
        set_req(0, 1'b1, 1'b1, 2'd0, d0[0]);
        set_req(1, 1'b1, 1'b1, 2'd0, d1[0]);
        for (int g = 0; g < 8; g++) begin
            exp_id = RR_MODE ? g[0] : (g >= 4);
            @(negedge clk);
            check("cont_gnt", {gnt1, gnt0}, exp_id ? 2'b10 : 2'b01);
            check("cont_ram_addr", ram_addr, exp_id ? k1 : k0);
            check("cont_ram_din", ram_din, exp_id ? d1[k1] : d0[k0]);
            if (exp_id) begin
                k1++;
                if (k1 == 4) req1 = 1'b0;
                else begin addr1 = k1[AW-1:0]; din1 = d1[k1]; end
            end else begin
                k0++;
                if (k0 == 4) req0 = 1'b0;
                else begin addr0 = k0[AW-1:0]; din0 = d0[k0]; end
            end
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) do_read(0, k[AW-1:0], d1[k]);

        // req1 pulses for one cycle while the FSM sits in RDWAIT
        set_req(0, 1'b1, 1'b0, 2'd1, '0);
        @(negedge clk);
        check("wd_gnt", {gnt1, gnt0}, 2'b01);
        req0 = 1'b0;
        @(negedge clk);
        set_req(1, 1'b1, 1'b1, 2'd2, 1'b1);
        @(negedge clk);
        req1 = 1'b0;
        check("wd_rvalid0", rvalid0, 1);
        check("wd_rdata0", rdata0, 1);
        check("wd_gnt1_a", gnt1, 0);
        @(negedge clk);
        check("wd_gnt1_b", gnt1, 0);
        check("wd_ram_we", ram_we, 0);
        check("wd_ram_addr", ram_addr, 1);
        @(negedge clk);
        check("wd_gnt1_c", gnt1, 0);
        check("wd_mem2", mem[2], 0);

        // Reset while the read is in RDWAIT
        set_req(0, 1'b1, 1'b0, 2'd1, '0);
        @(negedge clk);
        check("rst_rd_gnt", gnt0, 1);
        req0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_cleared("rst_mid");
        rst = 1'b0;
        set_req(0, 1'b1, 1'b0, 2'd1, '0);
        set_req(1, 1'b1, 1'b0, 2'd3, '0);
        @(negedge clk);
        check("rst_tie_gnt", {gnt1, gnt0}, 2'b01);
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tie_rvalid0", rvalid0, 1);
        check("rst_tie_rdata0", rdata0, 1);
        @(negedge clk);
        check("rst_tie_gnt1", {gnt1, gnt0}, 2'b10);
        req1 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tie_rvalid1", rvalid1, 1);
        check("rst_tie_rdata1", rdata1, 0);

        // Back-to-back reads from requester 1 with req held
        set_req(1, 1'b1, 1'b0, 2'd1, '0);
        @(negedge clk);
        check("b2b_gnt1_a", {gnt1, gnt0}, 2'b10);
        addr1 = 2'd3;
        @(negedge clk);
        check("b2b_idle_a", {gnt1, rvalid1}, 0);
        @(negedge clk);
        check("b2b_rvalid_a", {gnt1, rvalid1}, 2'b01);
        check("b2b_rdata_a", rdata1, 1);
        @(negedge clk);
        check("b2b_gnt1_b", {gnt1, rvalid1}, 2'b10);
        check("b2b_addr_b", ram_addr, 3);
        req1 = 1'b0;
        @(negedge clk);
        check("b2b_idle_b", {gnt1, rvalid1}, 0);
        @(negedge clk);
        check("b2b_rvalid_b", {gnt1, rvalid1}, 2'b01);
        check("b2b_rdata_b", rdata1, 0);
        @(negedge clk);
        check("b2b_rdata_hold", rdata1, 0);
        check("b2b_rvalid_end", rvalid1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
